jtgng_ram_dma: RTL and testbench

Sequencer that copies a contiguous block of LEN words from a CPU-shared source RAM into a private destination buffer, e.g. object RAM into the object line-buffer scratch during blanking. Obtains the CPU bus by a request/acknowledge handshake, streams reads through the source RAM's one-cycle registered read port, and drives the write port of the destination dual-port RAM. Runs on the pixel clock with a clock enable, sharing `cen` with the RAM ports it sequences.

---
 rtl/jtgng_ram_dma.sv | 167 ++++++++++++++++
 tb/tb_jtgng_ram_dma.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_ram_dma.sv
// jtgng_ram_dma
// Copies LEN words from a CPU-shared source RAM into a private destination
// RAM. The CPU bus is taken with a bus_req/bus_ack handshake, reads stream
// through the source RAM's one-cycle registered read port, and each returned
// word is presented on the destination write port. Everything advances on
// ticks (clk edges with cen=1). The only exceptions are the start latch and
// the done clear, which act on every clk edge.
//
// Ports:
//   rst, clk, cen      synchronous active-high reset, clock, clock enable
//   start              transfer request (latched while idle)
//   busy, done         transfer in progress / one-clk completion pulse
//   bus_req, bus_ack   CPU bus request / grant
//   src_addr, src_q    source read address / data (valid one tick later)
//   dst_addr, dst_data, dst_we   destination write port
module jtgng_ram_dma #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 9,
    parameter int unsigned LEN = 384
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          bus_req,
    input  logic          bus_ack,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_q,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data,
    output logic          dst_we
);

    typedef enum logic [1:0] {IDLE, REQ, COPY, DONE} state_t;

    localparam logic [AW:0]   LEN_C  = (AW+1)'(LEN);
    localparam logic [AW-1:0] LAST_A = AW'(LEN-1);

    state_t        state, state_nx;
    logic          pending, pending_nx;
    logic          rd_valid, rd_valid_nx;
    logic [AW:0]   wr_cnt, wr_cnt_nx;
    logic          busy_nx, done_nx, bus_req_nx, dst_we_nx;
    logic [AW-1:0] src_addr_nx, dst_addr_nx;
    logic [DW-1:0] dst_data_nx;
    logic [AW-1:0] src_addr_inc, src_addr_rew;

    // Reads saturate on the last word, so the extra reads issued while the
    // final captures drain stay inside the block.
    // On grant loss, the read address rewinds to the first uncaptured word.
    // It is clamped so that LEN = 2**AW cannot wrap.
    always_comb begin
        src_addr_inc = (src_addr < LAST_A) ? src_addr + 1'b1 : LAST_A;
        src_addr_rew = (wr_cnt >= LEN_C) ? LAST_A : wr_cnt[AW-1:0];
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            rd_valid <= 1'b0;
            wr_cnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bus_req  <= 1'b0;
            src_addr <= '0;
            dst_addr <= '0;
            dst_data <= '0;
            dst_we   <= 1'b0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            rd_valid <= rd_valid_nx;
            wr_cnt   <= wr_cnt_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            bus_req  <= bus_req_nx;
            src_addr <= src_addr_nx;
            dst_addr <= dst_addr_nx;
            dst_data <= dst_data_nx;
            dst_we   <= dst_we_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (cen) begin
            case (state)
                IDLE: if (pending || start) state_nx = REQ;
                REQ:  if (bus_ack) state_nx = COPY;
                COPY: begin
                    if (!bus_ack)             state_nx = REQ;
                    else if (wr_cnt == LEN_C) state_nx = DONE;
                end
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        pending_nx  = pending;
        rd_valid_nx = rd_valid;
        wr_cnt_nx   = wr_cnt;
        busy_nx     = busy;
        done_nx     = 1'b0;         // one-clk pulse, cleared regardless of cen
        bus_req_nx  = bus_req;
        src_addr_nx = src_addr;
        dst_addr_nx = dst_addr;
        dst_data_nx = dst_data;
        dst_we_nx   = dst_we;
        case (state)
            IDLE: begin
                if (start) pending_nx = 1'b1;
                if (cen && (pending || start)) begin
                    pending_nx  = 1'b0;
                    busy_nx     = 1'b1;
                    bus_req_nx  = 1'b1;
                    src_addr_nx = '0;
                    wr_cnt_nx   = '0;
                end
            end
            REQ: begin
                if (cen && bus_ack) begin
                    rd_valid_nx = 1'b1;
                    src_addr_nx = src_addr_inc;
                end
            end
            COPY: begin
                if (cen) begin
                    if (bus_ack) begin
                        // No capture once all LEN words are in, so the tick
                        // that moves to DONE only drops the write strobe.
                        if (rd_valid && wr_cnt != LEN_C) begin
                            dst_addr_nx = wr_cnt[AW-1:0];
                            dst_data_nx = src_q;
                            dst_we_nx   = 1'b1;
                            wr_cnt_nx   = wr_cnt + 1'b1;
                        end else begin
                            dst_we_nx   = 1'b0;
                        end
                        src_addr_nx = src_addr_inc;
                    end else begin
                        dst_we_nx   = 1'b0;
                        rd_valid_nx = 1'b0;
                        src_addr_nx = src_addr_rew;
                    end
                end
            end
            DONE: begin
                if (cen) begin
                    dst_we_nx  = 1'b0;
                    bus_req_nx = 1'b0;
                    busy_nx    = 1'b0;
                    done_nx    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtgng_ram_dma.sv
// Bench for jtgng_ram_dma. It drives the DMA against a source RAM model and
// compares every destination write against a queue of expected writes. The
// queue is filled from the source contents when a transfer is requested.
// Ports: none (top-level bench).
module tb_jtgng_ram_dma;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int LEN = 4;   // LEN = 2**AW: full address range

    logic          rst, clk, cen, start, bus_ack;
    logic          busy, done, bus_req, dst_we;
    logic [AW-1:0] src_addr, dst_addr;
    logic [DW-1:0] src_q, dst_data;

    logic [DW-1:0] src_mem [LEN];
    logic [DW-1:0] dst_mem [LEN];
    logic [DW-1:0] fixed_data [LEN] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int tk       = 0;
    int done_run = 0;
    bit gate     = 0;

    jtgng_ram_dma #(.DW(DW), .AW(AW), .LEN(LEN)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .src_addr (src_addr),
        .src_q    (src_q),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM: registered read port, enabled by cen
    always @(posedge clk) if (cen) src_q <= src_mem[src_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: at mid-cycle, a write that the next tick will commit is popped
    // from the scoreboard and stored in the destination model.
    always @(negedge clk) begin
        if (cen && dst_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", dst_addr, dst_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(dst_addr), 32'(mon_e.a));
                check("wr_data", 32'(dst_data), 32'(mon_e.d));
            end
            dst_mem[dst_addr] = dst_data;
        end
        if (done) done_run++;
        else if (done_run != 0) begin
            check("done_width", done_run, 1);
            done_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One tick. With gating on, three cen=0 edges come first; no output except
    // done may change across them.
    task automatic tick();
        logic [31:0] snap;
        if (gate) begin
            snap = 32'({busy, bus_req, src_addr, dst_addr, dst_data, dst_we});
            cen = 1'b0;
            repeat (3) step();
            check("gated_hold", 32'({busy, bus_req, src_addr, dst_addr, dst_data, dst_we}), snap);
            cen = 1'b1;
        end
        step();
        tk++;
    endtask

    // One full transfer. The expected writes are the LEN source words, in
    // order, exactly once. Once the last grant is seen, done is expected
    // after (remaining words + 2) ticks.
    task automatic run_xfer(input int delay, input int loss_at, input int loss_len,
                            input bit pre_pend, input bit mid_start, input bit fixed);
        int caps, seg, g;
        bit lost, ms;
        caps = 0; seg = 0; lost = 0; ms = 0;
        for (int k = 0; k < LEN; k++) begin
            src_mem[k] = fixed ? fixed_data[k] : DW'($urandom_range(0, 255));
            dst_mem[k] = ~src_mem[k];
            exp_q.push_back(wr_t'{a: AW'(k), d: src_mem[k]});
        end
        check("idle_busy", busy, 0);
        bus_ack = (delay == 0);
        if (pre_pend) begin
            cen = 1'b0; start = 1'b1; step();
            start = 1'b0; cen = 1'b1; tick();
        end else begin
            start = 1'b1; tick(); start = 1'b0;
        end
        check("req_after_start", 32'({busy, bus_req}), 32'h3);
        for (int i = 0; i < delay; i++) begin
            check("wait_we", dst_we, 0);
            check("wait_src_addr", 32'(src_addr), 0);
            check("wait_bus_req", bus_req, 1);
            tick();
        end
        bus_ack = 1'b1;
        tick();
        g = tk;
        for (int i = 0; i < 60 && !done; i++) begin
            if (!lost && loss_at >= 0 && dst_we && dst_addr == AW'(loss_at)) begin
                lost = 1;
                bus_ack = 1'b0;
                for (int j = 0; j < loss_len; j++) begin
                    tick();
                    check("loss_bus_req", bus_req, 1);
                    check("loss_we", dst_we, 0);
                    check("loss_rewind", 32'(src_addr), caps);
                end
                bus_ack = 1'b1;
                tick();
                g = tk;
                seg = caps;
            end else begin
                if (mid_start && !ms && caps == 1) begin
                    start = 1'b1;
                    ms = 1;
                end
                tick();
                start = 1'b0;
                if (dst_we) caps++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within bound");
        end else begin
            check("done_latency", tk - g, LEN - seg + 2);
        end
        check("bus_req_released", bus_req, 0);
        check("busy_cleared", busy, 0);
        check("sb_empty", exp_q.size(), 0);
        for (int k = 0; k < LEN; k++) check("dst_content", 32'(dst_mem[k]), 32'(src_mem[k]));
        if (gate) cen = 1'b0;
        step();
        check("done_clear", done, 0);
        cen = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int caps, la;
        rst = 1'b1; cen = 1'b1; start = 1'b0; bus_ack = 1'b0;
        for (int k = 0; k < LEN; k++) begin
            src_mem[k] = '0;
            dst_mem[k] = '0;
        end
        repeat (3) step();
        check("reset_outputs",
              32'({busy, done, bus_req, src_addr, dst_addr, dst_data, dst_we}), 0);
        rst = 1'b0;
        step();

        // Basic copy, delayed grant, grant loss after word 1
        run_xfer(0, -1, 0, 0, 0, 1);
        run_xfer(5, -1, 0, 0, 0, 1);
        run_xfer(0, 1, 3, 0, 0, 1);

        // cen active one clk in four
        gate = 1;
        run_xfer(0, -1, 0, 0, 0, 0);
        run_xfer(2, 0, 2, 0, 0, 0);
        gate = 0;

        // start latched while cen=0, then a start mid-copy that must be ignored
        run_xfer(0, -1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_second_xfer", 32'({busy, bus_req}), 0);
        end

        // Reset after two captures
        for (int k = 0; k < LEN; k++) begin
            src_mem[k] = fixed_data[k];
            exp_q.push_back(wr_t'{a: AW'(k), d: src_mem[k]});
        end
        bus_ack = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        caps = 0;
        for (int i = 0; i < 20 && caps < 2; i++) begin
            tick();
            if (dst_we) caps++;
        end
        check("caps_before_reset", caps, 2);
        rst = 1'b1;
        step();
        check("midreset_outputs",
              32'({busy, done, bus_req, src_addr, dst_addr, dst_data, dst_we}), 0);
        rst = 1'b0;
        bus_ack = 1'b0;
        exp_q.delete();
        step();
        run_xfer(1, -1, 0, 0, 0, 0);

        // Random grant timing and grant losses
        for (int r = 0; r < 4; r++) begin
            la = int'($urandom_range(0, 3)) - 1;
            run_xfer(int'($urandom_range(0, 3)), la, int'($urandom_range(1, 3)), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
